// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM state encoding and default bus width.
package apb_pkg;

   localparam int unsigned APB_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      READY = 2'd2
   } apb_state_e;

endpackage

// File: rtl/apb_slave_regfile_if.sv
// APB bus bundle between a bridge (master) and a slave.
interface apb_slave_regfile_if
   import apb_pkg::*;
#(
   parameter int unsigned WIDTH = APB_WIDTH
) ();

   logic             pselect;
   logic             penable;
   logic             pwrite;
   logic [WIDTH-1:0] paddr;
   logic [WIDTH-1:0] pwdata;
   logic             pready;
   logic [WIDTH-1:0] prdata;
   logic             pslverr;

   modport master (
      output pselect, penable, pwrite, paddr, pwdata,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  pselect, penable, pwrite, paddr, pwdata,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_regfile_mem.sv
// Register array with one synchronous write port and one combinational read port.
module apb_regfile_mem
   import apb_pkg::*;
#(
   parameter int unsigned WIDTH = APB_WIDTH,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage: cleared by reset, written when we is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB slave exposing DEPTH registers with a fixed number of wait states.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int unsigned WIDTH       = APB_WIDTH,
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_STATES = 1
) (
   input logic                 pclk,
   input logic                 preset,
   apb_slave_regfile_if.slave  bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   apb_state_e       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic             write_q, write_d;
   logic             pready_q, pslverr_q;
   logic [WIDTH-1:0] prdata_q;
   logic [WIDTH-1:0] mem_rdata;
   logic             setup;
   logic             in_range_q, in_range_d;
   logic             mem_we;

   assign setup = bus.pselect & ~bus.penable;

   // Upper address bits all zero means the word exists in the array.
   assign in_range_q = (addr_q >> AW) == '0;
   assign in_range_d = (addr_d >> AW) == '0;

   // Commit on the edge leaving READY, unless the bridge deselected us.
   assign mem_we = (state_q == READY) & bus.pselect & write_q & in_range_q;

   apb_regfile_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (pclk),
      .reset (preset),
      .we    (mem_we),
      .waddr (addr_q[AW-1:0]),
      .wdata (wdata_q),
      .raddr (addr_d[AW-1:0]),
      .rdata (mem_rdata)
   );

   // Next-state logic: latch on setup, count wait states, abort on deselect.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               addr_d  = bus.paddr;
               wdata_d = bus.pwdata;
               write_d = bus.pwrite;
               if (WAIT_STATES == 0) begin
                  state_d = READY;
               end else begin
                  state_d = WAIT;
                  cnt_d   = WAIT_INIT;
               end
            end
         end
         WAIT: begin
            if (!bus.pselect) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == '0) begin
               state_d = READY;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         READY: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and transfer latch registers.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
      end
   end

   // Registered bus outputs, loaded on the edge that enters READY.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         pready_q  <= (state_d == READY);
         pslverr_q <= (state_d == READY) & ~in_range_d;
         if (state_d == READY) begin
            if (!in_range_d) begin
               prdata_q <= '0;
            end else if (!write_d) begin
               prdata_q <= mem_rdata;
            end
         end
      end
   end

   assign bus.pready  = pready_q;
   assign bus.pslverr = pslverr_q;
   assign bus.prdata  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench: a zero-wait and a three-wait slave behind one shared bridge model.
module tb_apb_slave_regfile;

   logic        pclk;
   logic        preset;
   bit          sel;
   logic        psel, pen, pwr;
   logic [15:0] paddr, pwdata;
   logic        rdy, err;
   logic [15:0] rdat;

   int checks;
   int failures;

   logic [15:0] model [2][16];

   apb_slave_regfile_if #(.WIDTH(16)) bus0 ();
   apb_slave_regfile_if #(.WIDTH(16)) bus3 ();

   assign bus0.pselect = psel & ~sel;
   assign bus0.penable = pen;
   assign bus0.pwrite  = pwr;
   assign bus0.paddr   = paddr;
   assign bus0.pwdata  = pwdata;
   assign bus3.pselect = psel & sel;
   assign bus3.penable = pen;
   assign bus3.pwrite  = pwr;
   assign bus3.paddr   = paddr;
   assign bus3.pwdata  = pwdata;

   assign rdy  = sel ? bus3.pready  : bus0.pready;
   assign err  = sel ? bus3.pslverr : bus0.pslverr;
   assign rdat = sel ? bus3.prdata  : bus0.prdata;

   apb_slave_regfile #(.WIDTH(16), .DEPTH(16), .WAIT_STATES(0)) dut0 (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus0)
   );

   apb_slave_regfile #(.WIDTH(16), .DEPTH(16), .WAIT_STATES(3)) dut3 (
      .pclk   (pclk),
      .preset (preset),
      .bus    (bus3)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   typedef struct {
      bit          s;
      bit          wr;
      logic [15:0] a;
      logic [15:0] d;
      logic [15:0] exp_rd;
      bit          exp_err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 2; i++)
         for (int j = 0; j < 16; j++)
            model[i][j] = '0;
   endtask

   function automatic logic [15:0] model_read(input bit s, input logic [15:0] a);
      return (a < 16) ? model[s][a[3:0]] : 16'h0;
   endfunction

   task automatic model_write(input bit s, input logic [15:0] a, input logic [15:0] d);
      if (a < 16) model[s][a[3:0]] = d;
   endtask

   task automatic idle();
      @(posedge pclk); #1;
      psel = 1'b0; pen = 1'b0;
   endtask

   // One full bridge transfer; pready must appear in access cycle (wait states + 1) only.
   task automatic xfer(input bit s, input bit wr, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic er);
      int ws;
      ws = s ? 3 : 0;
      @(posedge pclk); #1;
      sel = s; psel = 1'b1; pen = 1'b0; pwr = wr; paddr = a; pwdata = d;
      check("setup_pready", rdy, 0);
      for (int k = 1; k <= ws + 1; k++) begin
         @(posedge pclk); #1;
         pen = 1'b1;
         check("pready_cycle", rdy, (k == ws + 1));
      end
      rd = rdat;
      er = err;
   endtask

   logic [15:0] rd;
   logic        er;

   initial begin
      #1000000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0; failures = 0;
      preset = 1'b1; sel = 1'b0; psel = 1'b0; pen = 1'b0; pwr = 1'b0;
      paddr = '0; pwdata = '0;
      clear_model();

      // Reset state of both slaves.
      repeat (2) @(posedge pclk);
      #1;
      check("rst_pready0",  bus0.pready,  0);
      check("rst_pslverr0", bus0.pslverr, 0);
      check("rst_prdata0",  bus0.prdata,  0);
      check("rst_pready3",  bus3.pready,  0);
      check("rst_pslverr3", bus3.pslverr, 0);
      check("rst_prdata3",  bus3.prdata,  0);
      preset = 1'b0;

      // Directed vectors, applied back to back.
      vecs.push_back('{1'b1, 1'b0, 16'd5,  16'h0000, 16'h0000, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 16'd3,  16'h1234, 16'h0000, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 16'd3,  16'h0000, 16'h1234, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 16'd0,  16'h000A, 16'h0000, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 16'd1,  16'h000B, 16'h0000, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 16'd2,  16'h000C, 16'h0000, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 16'd0,  16'h0000, 16'h000A, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 16'd1,  16'h0000, 16'h000B, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 16'd2,  16'h0000, 16'h000C, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 16'd16, 16'hFFFF, 16'h0000, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 16'd0,  16'h0000, 16'h000A, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 16'd16, 16'h0000, 16'h0000, 1'b1});
      vecs.push_back('{1'b1, 1'b1, 16'd4,  16'h0BEE, 16'h0000, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 16'd31, 16'h4321, 16'h0000, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 16'd4,  16'h0000, 16'h0BEE, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 16'd4,  16'h0000, 16'h0000, 1'b0});
      foreach (vecs[i]) begin
         xfer(vecs[i].s, vecs[i].wr, vecs[i].a, vecs[i].d, rd, er);
         check("vec_pslverr", er, vecs[i].exp_err);
         if (!vecs[i].wr) check("vec_prdata", rd, vecs[i].exp_rd);
         if (vecs[i].wr) model_write(vecs[i].s, vecs[i].a, vecs[i].d);
      end
      idle();

      // Deselect during WAIT: no write, pready never rises.
      @(posedge pclk); #1;
      sel = 1'b1; psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 16'd7; pwdata = 16'h5555;
      @(posedge pclk); #1;
      pen = 1'b1;
      check("abort_wait_pready", rdy, 0);
      for (int k = 0; k < 6; k++) begin
         @(posedge pclk); #1;
         psel = 1'b0; pen = 1'b0;
         check("abort_wait_pready", rdy, 0);
      end
      xfer(1'b1, 1'b0, 16'd7, 16'h0, rd, er);
      check("abort_wait_readback", rd, model_read(1'b1, 16'd7));
      idle();

      // Deselect during READY on the zero-wait slave: write suppressed.
      @(posedge pclk); #1;
      sel = 1'b0; psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 16'd9; pwdata = 16'h7777;
      @(posedge pclk); #1;
      psel = 1'b0; pen = 1'b0;
      @(posedge pclk); #1;
      check("abort_ready_pready_next", rdy, 0);
      xfer(1'b0, 1'b0, 16'd9, 16'h0, rd, er);
      check("abort_ready_readback", rd, model_read(1'b0, 16'd9));
      idle();

      // penable without a setup cycle is ignored.
      for (int k = 0; k < 3; k++) begin
         @(posedge pclk); #1;
         sel = 1'b0; psel = 1'b1; pen = 1'b1; pwr = 1'b0; paddr = 16'd3;
         check("no_setup_pready", rdy, 0);
      end
      idle();

      // A setup-looking cycle inside WAIT must not restart the count.
      @(posedge pclk); #1;
      sel = 1'b1; psel = 1'b1; pen = 1'b0; pwr = 1'b0; paddr = 16'd4;
      for (int k = 1; k <= 4; k++) begin
         @(posedge pclk); #1;
         pen = (k != 2);
         check("wait_setup_pready", rdy, (k == 4));
      end
      check("wait_setup_prdata", rdat, model_read(1'b1, 16'd4));
      idle();

      // Reset during WAIT (three-wait slave).
      @(posedge pclk); #1;
      sel = 1'b1; psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 16'd2; pwdata = 16'h2222;
      @(posedge pclk); #1;
      pen = 1'b1;
      @(posedge pclk); #1;
      preset = 1'b1; psel = 1'b0; pen = 1'b0;
      #1;
      check("rst_wait_pready", rdy, 0);
      @(posedge pclk); #1;
      preset = 1'b0;
      clear_model();

      // Reset while the zero-wait slave shows pready: drops without a clock edge.
      @(posedge pclk); #1;
      sel = 1'b0; psel = 1'b1; pen = 1'b0; pwr = 1'b1; paddr = 16'd2; pwdata = 16'h2222;
      @(posedge pclk); #1;
      pen = 1'b1;
      check("rst_ready_before", rdy, 1);
      #2;
      preset = 1'b1;
      #1;
      check("rst_ready_async", rdy, 0);
      psel = 1'b0; pen = 1'b0;
      @(posedge pclk); #1;
      preset = 1'b0;
      xfer(1'b0, 1'b0, 16'd2, 16'h0, rd, er);
      check("rst_readback0_a2", rd, 16'h0000);
      xfer(1'b1, 1'b0, 16'd2, 16'h0, rd, er);
      check("rst_readback3_a2", rd, 16'h0000);
      xfer(1'b0, 1'b0, 16'd0, 16'h0, rd, er);
      check("rst_readback0_a0", rd, 16'h0000);
      idle();

      // Random traffic against the array model.
      for (int n = 0; n < 80; n++) begin
         bit          s, wr;
         logic [15:0] a, d;
         s  = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = 16'($urandom_range(0, 19));
         d  = 16'($urandom);
         if ($urandom_range(0, 3) == 0) idle();
         xfer(s, wr, a, d, rd, er);
         check("rand_pslverr", er, (a >= 16));
         if (!wr) check("rand_prdata", rd, model_read(s, a));
         else model_write(s, a, d);
      end
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
APB_SLAVE_REGFILE -- requirements
Module: apb_slave_regfile

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data and address bus width.
REQ-002 SHALL have parameter DEPTH, default 16, number of WIDTH-bit registers (power of two, 2..256).
REQ-003 SHALL have parameter WAIT_STATES, default 1, access cycles with pready low before completion (0..15).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 pclk  input  1  peripheral clock; all state changes on rising edge.
REQ-006 preset  input  1  asynchronous active-high reset.
REQ-007 pselect  input  1  slave select from the APB bridge.
REQ-008 penable  input  1  access-phase strobe from the bridge.
REQ-009 pwrite  input  1  1 = write, 0 = read.
REQ-010 paddr  input  WIDTH  word address.
REQ-011 pwdata  input  WIDTH  write data.
REQ-012 pready  output  1  transfer completion, registered.
REQ-013 prdata  output  WIDTH  read data, registered, valid while pready=1.
REQ-014 pslverr  output  1  error flag, valid only while pready=1.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and READY.
REQ-016 Setup cycle is defined as pselect=1 and penable=0.
REQ-017 IDLE: on a setup cycle, latch paddr, pwrite and pwdata. Go to READY if WAIT_STATES=0. Otherwise go to WAIT with counter = WAIT_STATES-1.
REQ-018 WAIT: while pselect=1, decrement counter if >0. Go to READY on the edge where counter=0.
REQ-019 Net timing: pready SHALL be 1 in exactly access cycle WAIT_STATES+1 after the setup cycle, and 0 in all other cycles.
REQ-020 READY: pready=1 for exactly one cycle. Next state is IDLE, so a bridge setup in the following cycle is accepted with no bubble.
REQ-021 Reads: prdata SHALL be loaded with reg[latched addr] on the edge that enters READY. prdata holds its value until the next load.
REQ-022 Writes: reg[latched addr] <= latched pwdata on the edge leaving READY, only if pwrite=1 and the address is in range.
REQ-023 Out-of-range address (paddr >= DEPTH): pslverr=1 together with pready. The write is suppressed, prdata=0, and the same wait timing applies.
REQ-024 pselect low in WAIT or READY (aborted transfer): next state IDLE, no register write, pready=0 next cycle.
REQ-025 IDLE with penable=1 and no preceding setup cycle: ignored, remain in IDLE.
REQ-026 A setup cycle seen while in WAIT SHALL NOT restart the transfer.
REQ-027 Register contents SHALL be unaffected by reads.

Reset
REQ-028 preset=1 SHALL, asynchronously: set state=IDLE, pready=0, pslverr=0, prdata=0, counter=0, all registers=0.
REQ-029 Reset asserted mid-transfer SHALL abandon the transfer with no register write. The first setup cycle after reset release is served normally.

Structure
REQ-030 Shared package apb_pkg SHALL hold the FSM state enum (IDLE, WAIT, READY) and the default WIDTH constant, for reuse by the bridge.
REQ-031 Register array plus write port SHALL be a sub-module apb_regfile_mem (ports: clk, reset, we, waddr, wdata, raddr, rdata).
REQ-032 FSM, counter, address decode and error logic SHALL reside in apb_slave_regfile.

Verification
REQ-033 WAIT_STATES=0, write 0x1234 to addr 3 then read addr 3 -> pready high in the first access cycle each time; read returns 0x1234; pslverr=0.
REQ-034 WAIT_STATES=3, read addr 5 -> pready low for 3 access cycles, high in the 4th; prdata=0 after reset.
REQ-035 Bridge back-to-back writes to addr 0, 1, 2 (data 0xA, 0xB, 0xC) -> each completes; readback returns 0xA, 0xB, 0xC.
REQ-036 Write 0xFFFF to addr 16 (DEPTH=16) -> pslverr=1 with pready; a read of addr 0 is unchanged.
REQ-037 Drop pselect during WAIT of a write 0x5555 to addr 7 -> no write; readback of addr 7 = 0; pready never asserted for that transfer.
REQ-038 Assert preset during WAIT of a write to addr 2 -> pready=0 immediately; addr 2 reads 0 after reset release.
